// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD execute stage.
//   alu_op_e   : 4-bit ALUControlE encodings (12-15 are illegal)
//   ex_state_e : execute-stage FSM states
//   lane_op_e  : operation select for one simd_lane_alu
//   ex_ctrl_t  : control bundle carried into the EX/MEM register
package simd_pkg;

    localparam int unsigned SIMD_LANES  = 4;
    localparam int unsigned SIMD_LANE_W = 8;
    localparam int unsigned SIMD_WA_W   = 3;

    typedef enum logic [3:0] {
        OpAdd    = 4'd0,
        OpSub    = 4'd1,
        OpAnd    = 4'd2,
        OpOr     = 4'd3,
        OpXor    = 4'd4,
        OpVadd8  = 4'd5,
        OpVsub8  = 4'd6,
        OpVadds8 = 4'd7,
        OpVmul8  = 4'd8,
        OpPassB  = 4'd9,
        OpShl    = 4'd10,
        OpShr    = 4'd11
    } alu_op_e;

    typedef enum logic {
        StIdle,
        StMul
    } ex_state_e;

    typedef enum logic [1:0] {
        LaneAdd,
        LaneSub,
        LaneSadd,
        LaneMul
    } lane_op_e;

    typedef struct packed {
        logic                 pcsrc;
        logic                 regwrite;
        logic                 memtoreg;
        logic                 memwrite;
        logic [SIMD_WA_W-1:0] wa3;
    } ex_ctrl_t;

    // Codes 12-15 have no operation behind them.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return op >= 4'd12;
    endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One SIMD lane: combinational add / sub / unsigned saturating add / low-half multiply.
//   a_i, b_i : lane operands (W bits)
//   op_i     : lane operation
//   y_o      : lane result, modulo 2^W except LaneSadd which clamps to all-ones
module simd_lane_alu
    import simd_pkg::*;
#(
    parameter int unsigned W = SIMD_LANE_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  lane_op_e     op_i,
    output logic [W-1:0] y_o
);

    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        y_o = '0;
        unique case (op_i)
            LaneAdd:  y_o = sum[W-1:0];
            LaneSub:  y_o = a_i - b_i;
            LaneSadd: y_o = sum[W] ? '1 : sum[W-1:0];
            LaneMul:  y_o = a_i * b_i;
            default:  y_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the SIMD pipeline; owns the EX/MEM register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   ValidE, FlushE       : ID/EX holds an instruction / kill it (and any multiply in flight)
//   *E controls, operands: decoded instruction from ID/EX
//   StallE               : combinational hold request to IF/ID/EX
//   *M                   : registered controls, result and store data for the memory stage
// Single-cycle ops land in M one edge after acceptance. VMUL8 is done one lane per cycle
// through lane 0's ALU and lands in M LANES+1 edges after acceptance.
module execute_stage
    import simd_pkg::*;
#(
    parameter int unsigned LANES  = SIMD_LANES,
    parameter int unsigned LANE_W = SIMD_LANE_W,
    parameter int unsigned WA_W   = SIMD_WA_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ValidE,
    input  logic                    FlushE,
    input  logic                    PCSrcE,
    input  logic                    RegWriteE,
    input  logic                    MemtoRegE,
    input  logic                    MemWriteE,
    input  logic [3:0]              ALUControlE,
    input  logic [LANES*LANE_W-1:0] SrcAE,
    input  logic [LANES*LANE_W-1:0] SrcBE,
    input  logic [LANES*LANE_W-1:0] WriteDataE,
    input  logic [WA_W-1:0]         WA3E,
    output logic                    StallE,
    output logic                    PCSrcM,
    output logic                    RegWriteM,
    output logic                    MemtoRegM,
    output logic                    MemWriteM,
    output logic [LANES*LANE_W-1:0] ALUResultM,
    output logic [LANES*LANE_W-1:0] WriteDataM,
    output logic [WA_W-1:0]         WA3M
);

    localparam int unsigned DW       = LANES * LANE_W;
    localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LaneIdxW-1:0] LastLane = LaneIdxW'(LANES - 1);

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

    // FSM and multiply working state
    ex_state_e           state_q, state_d;
    logic [LaneIdxW-1:0] lane_q, lane_d;
    lanes_t              mul_a_q, mul_a_d;
    lanes_t              mul_b_q, mul_b_d;
    lanes_t              mul_res_q, mul_res_d;
    logic [DW-1:0]       mul_wd_q, mul_wd_d;
    ex_ctrl_t            mul_ctrl_q, mul_ctrl_d;

    // EX/MEM register
    ex_ctrl_t            ctrl_m_q, ctrl_m_d;
    logic [DW-1:0]       res_m_q, res_m_d;
    logic [DW-1:0]       wd_m_q, wd_m_d;

    lanes_t              src_a_lanes, src_b_lanes, lane_y;
    lane_op_e            vec_op;
    logic [DW-1:0]       alu_res;
    logic                mul_active;
    logic                stall;
    ex_ctrl_t            ctrl_e;

    assign src_a_lanes = SrcAE;
    assign src_b_lanes = SrcBE;
    assign mul_active  = (state_q == StMul);

    always_comb begin
        vec_op = LaneAdd;
        case (ALUControlE)
            OpVsub8:  vec_op = LaneSub;
            OpVadds8: vec_op = LaneSadd;
            OpVmul8:  vec_op = LaneMul;
            default:  vec_op = LaneAdd;
        endcase
    end

    // Lane 0 doubles as the sequential multiplier while in StMul.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] a_l, b_l;
        lane_op_e          op_l;
        if (g == 0) begin : g_shared
            assign a_l  = mul_active ? mul_a_q[lane_q] : src_a_lanes[g];
            assign b_l  = mul_active ? mul_b_q[lane_q] : src_b_lanes[g];
            assign op_l = mul_active ? LaneMul : vec_op;
        end else begin : g_plain
            assign a_l  = src_a_lanes[g];
            assign b_l  = src_b_lanes[g];
            assign op_l = vec_op;
        end
        simd_lane_alu #(
            .W(LANE_W)
        ) u_lane_alu (
            .a_i (a_l),
            .b_i (b_l),
            .op_i(op_l),
            .y_o (lane_y[g])
        );
    end

    always_comb begin
        alu_res = '0;
        case (ALUControlE)
            OpAdd:    alu_res = SrcAE + SrcBE;
            OpSub:    alu_res = SrcAE - SrcBE;
            OpAnd:    alu_res = SrcAE & SrcBE;
            OpOr:     alu_res = SrcAE | SrcBE;
            OpXor:    alu_res = SrcAE ^ SrcBE;
            OpVadd8,
            OpVsub8,
            OpVadds8: alu_res = lane_y;
            OpPassB:  alu_res = SrcBE;
            OpShl:    alu_res = SrcAE << SrcBE[4:0];
            OpShr:    alu_res = SrcAE >> SrcBE[4:0];
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        ctrl_e.pcsrc    = PCSrcE;
        ctrl_e.regwrite = RegWriteE;
        ctrl_e.memtoreg = MemtoRegE;
        ctrl_e.memwrite = MemWriteE;
        ctrl_e.wa3      = WA3E;
    end

    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_res_d  = mul_res_q;
        mul_wd_d   = mul_wd_q;
        mul_ctrl_d = mul_ctrl_q;
        ctrl_m_d   = '0;
        res_m_d    = '0;
        wd_m_d     = '0;
        stall      = 1'b0;

        if (FlushE) begin
            state_d = StIdle;
            lane_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ValidE) begin
                        if (ALUControlE == OpVmul8) begin
                            stall      = 1'b1;
                            mul_a_d    = src_a_lanes;
                            mul_b_d    = src_b_lanes;
                            mul_wd_d   = WriteDataE;
                            mul_ctrl_d = ctrl_e;
                            mul_res_d  = '0;
                            lane_d     = '0;
                            state_d    = StMul;
                        end else begin
                            ctrl_m_d = ctrl_e;
                            if (is_illegal_op(ALUControlE)) begin
                                ctrl_m_d.pcsrc    = 1'b0;
                                ctrl_m_d.regwrite = 1'b0;
                                ctrl_m_d.memwrite = 1'b0;
                            end
                            res_m_d = alu_res;
                            wd_m_d  = WriteDataE;
                        end
                    end
                end
                StMul: begin
                    mul_res_d[lane_q] = lane_y[0];
                    if (lane_q == LastLane) begin
                        ctrl_m_d = mul_ctrl_q;
                        res_m_d  = mul_res_d;
                        wd_m_d   = mul_wd_q;
                        lane_d   = '0;
                        state_d  = StIdle;
                    end else begin
                        stall  = 1'b1;
                        lane_d = lane_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    lane_d  = '0;
                end
            endcase
        end
    end

    // A VMUL8 sitting in ID/EX while reset is held must not request a stall.
    assign StallE = stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            lane_q     <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_res_q  <= '0;
            mul_wd_q   <= '0;
            mul_ctrl_q <= '0;
            ctrl_m_q   <= '0;
            res_m_q    <= '0;
            wd_m_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_res_q  <= mul_res_d;
            mul_wd_q   <= mul_wd_d;
            mul_ctrl_q <= mul_ctrl_d;
            ctrl_m_q   <= ctrl_m_d;
            res_m_q    <= res_m_d;
            wd_m_q     <= wd_m_d;
        end
    end

    assign PCSrcM     = ctrl_m_q.pcsrc;
    assign RegWriteM  = ctrl_m_q.regwrite;
    assign MemtoRegM  = ctrl_m_q.memtoreg;
    assign MemWriteM  = ctrl_m_q.memwrite;
    assign WA3M       = ctrl_m_q.wa3;
    assign ALUResultM = res_m_q;
    assign WriteDataM = wd_m_q;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage of the SIMD pipeline, directly upstream of the memory stage.
- Takes decoded controls and operands from ID/EX and computes scalar or 4-lane x 8-bit SIMD results.
- Owns the EX/MEM pipeline register that feeds the memory stage: PCSrcM, RegWriteM, MemtoRegM, MemWriteM, ALUResultM, WriteDataM, WA3M.
- Lane multiply is multi-cycle and stalls upstream.

Parameters:
- LANES, 4, number of SIMD lanes.
- LANE_W, 8, bits per lane; LANES*LANE_W = 32.
- WA_W, 3, register write-address width.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- ValidE  in  1  ID/EX holds a real instruction
- FlushE  in  1  kill current/in-flight EX instruction
- PCSrcE, RegWriteE, MemtoRegE, MemWriteE  in  1 each  decoded controls
- ALUControlE  in  4  operation select
- SrcAE, SrcBE  in  32  operands
- WriteDataE  in  32  store data
- WA3E  in  WA_W  destination register
- StallE  out  1  hold IF/ID/EX (combinational)
- PCSrcM, RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered controls
- ALUResultM  out  32  registered result/address
- WriteDataM  out  32  registered store data
- WA3M  out  WA_W  registered destination

Behaviour:
- Reset: clk single clock; rst_n asynchronous, active-low. All M outputs 0; FSM IDLE; lane counter 0. StallE = 0 while in reset.
- Ops (ALUControlE):
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR: 32-bit, wrap.
  - 5 VADD8, 6 VSUB8: per-lane, modulo 256, no inter-lane carry.
  - 7 VADDS8: per-lane unsigned saturate to 0xFF.
  - 8 VMUL8: per-lane low 8 bits of the unsigned 8x8 product; multi-cycle.
  - 9 PASSB: result = SrcBE.
  - 10 SHL, 11 SHR logical: 32-bit, shift amount SrcBE[4:0].
  - 12-15 illegal: result 0; RegWriteM, MemWriteM, PCSrcM forced 0.
- Bubble: all four control outputs 0; data outputs hold don't-care, driven 0.
- FSM states:
  - IDLE:
    - ValidE=0: bubble into M.
    - Single-cycle op: result and controls registered at the next edge (latency 1).
    - VMUL8 with ValidE=1 (cycle T): StallE=1; latch SrcA, SrcB, WriteData, WA3 and controls; lane<=0; go to MUL; bubble into M.
  - MUL, one lane per cycle, cycles T+1..T+4:
    - Result byte[lane] <= product.
    - StallE=1 while lane!=LANES-1.
    - Lane LANES-1 (T+4): StallE=0; the full 32-bit result plus latched controls are registered into M at that edge; return to IDLE.
    - E inputs ignored throughout MUL.
    - Bubbles into M on T+1..T+3.
    - Acceptance-to-M latency is LANES+1 edges.
- FlushE:
  - Highest priority over everything except reset.
  - IDLE: bubble, no stall.
  - MUL: abort, return to IDLE, bubble, StallE=0 that cycle.
- StallE equation: (IDLE & ValidE & op==VMUL8 & ~FlushE) | (MUL & lane!=LANES-1 & ~FlushE).
- Reset mid-MUL: immediate return to IDLE, outputs 0, partial result discarded.
- Back-to-back VMUL8: the second is accepted in the IDLE cycle after the first completes.

Decomposition:
- simd_pkg:
  - alu_op_e enum (4-bit codes above)
  - ex_state_e {IDLE, MUL}
  - LANES, LANE_W defaults
  - ex_ctrl_t struct {pcsrc, regwrite, memtoreg, memwrite, wa3}
- Sub-module simd_lane_alu: combinational per-lane add/sub/sat-add/mul on LANE_W bits; instantiated LANES times for single-cycle ops. The MUL path reuses one instance, muxed by lane.

Test Plan:
- Reset, then ADD 0x00000005 + 0xFFFFFFFF with RegWriteE=1, WA3E=3 -> next edge ALUResultM=0x00000004, RegWriteM=1, WA3M=3, StallE=0 throughout.
- VADD8 0x80FF0102 + 0x80020304 -> 0x00010406. VADDS8 same operands -> 0xFFFF0406.
- VMUL8 0x02031011 * 0x80050210 -> StallE high for 4 cycles. ALUResultM=0x000F2010 appears on the 5th edge after acceptance; M controls are bubbles on the prior edges.
- VMUL8 in flight, FlushE=1 on T+2 -> StallE=0 that cycle, state IDLE, M bubble, no RegWriteM pulse.
- rst_n low asynchronously at T+3 of VMUL8 -> outputs 0 immediately, no clock edge needed. After release, an ADD completes normally.
- ALUControlE=13 with RegWriteE=1, MemWriteE=1 -> ALUResultM=0, RegWriteM=0, MemWriteM=0.
